// File: rtl/ld_unit_seq.sv
// Sequential load unit: merges an immediate byte into a lane of the A/B base operand,
// or reads a word from data memory over a req/ack handshake with a bounded wait.
module ld_unit_seq #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       ins,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NLANES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [DATA_W-1:0] out_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_req_reg;
    logic              err_reg;
    logic [7:0]        to_cnt_reg;

    // Instruction fields, only meaningful on the cycle start is accepted
    logic              sel_b;
    logic              is_imm;
    logic              indexed;
    logic [1:0]        lane;
    logic [7:0]        imm;
    logic [DATA_W-1:0] base;
    logic              lane_ok;
    logic [DATA_W-1:0] merged;
    logic [ADDR_W-1:0] addr_imm;
    logic [ADDR_W-1:0] addr_base;
    logic [ADDR_W-1:0] addr_calc;
    logic              accept;
    logic              ack_seen;
    logic              timeout_hit;

    assign sel_b   = ins[11];
    assign is_imm  = ins[10];
    assign indexed = ins[9];
    assign lane    = ins[9:8];
    assign imm     = ins[7:0];
    assign base    = sel_b ? b_in : a_in;

    // lane is only two bits wide, so compare at 32 bits to cover NLANES up to 8
    assign lane_ok = ({30'd0, lane} < 32'(NLANES));

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            assign merged[8*gi +: 8] = ({30'd0, lane} == 32'(gi)) ? imm : base[8*gi +: 8];
        end
    endgenerate

    assign addr_imm  = ADDR_W'(imm);
    assign addr_base = ADDR_W'(base);
    assign addr_calc = indexed ? (addr_imm + addr_base) : addr_imm;

    assign accept      = (state_reg == IDLE) && start;
    assign ack_seen    = mem_req_reg && mem_ack;
    assign timeout_hit = (to_cnt_reg == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = is_imm ? FIN : REQ;
                end
            end
            REQ: begin
                if (ack_seen || timeout_hit) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // err is a one-cycle pulse that lines up with FIN, so it is cleared by default
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg      <= '0;
            mem_addr_reg <= '0;
            mem_req_reg  <= 1'b0;
            err_reg      <= 1'b0;
            to_cnt_reg   <= '0;
        end else begin
            err_reg <= 1'b0;
            if (accept) begin
                if (is_imm) begin
                    if (lane_ok) begin
                        out_reg <= merged;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end else begin
                    mem_req_reg  <= 1'b1;
                    mem_addr_reg <= addr_calc;
                    to_cnt_reg   <= '0;
                end
            end else if (state_reg == REQ) begin
                if (ack_seen) begin
                    out_reg     <= mem_rdata;
                    mem_req_reg <= 1'b0;
                end else if (timeout_hit) begin
                    mem_req_reg <= 1'b0;
                    err_reg     <= 1'b1;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign out      = out_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_req  = mem_req_reg;
    assign err      = err_reg;
    assign done     = (state_reg == FIN);
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_ld_unit_seq.sv
// Directed bench for ld_unit_seq: a 16-bit instance for most steps, a 32-bit one for wide lanes.
module tb_ld_unit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ins = '0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic [15:0] out;
    logic        busy;
    logic        done;
    logic        err;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic [7:0]  mem_addr32;
    logic        mem_req32;
    logic [31:0] out32;
    logic        busy32;
    logic        done32;
    logic        err32;

    int n_assert = 0;
    int n_fail   = 0;
    int req_cnt;
    int done_at;

    always #5 clk = ~clk;

    ld_unit_seq #(.DATA_W(16), .ADDR_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .ins(ins), .a_in(a_in), .b_in(b_in),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out(out), .busy(busy), .done(done), .err(err)
    );

    ld_unit_seq #(.DATA_W(32), .ADDR_W(8), .TIMEOUT(15)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .ins(ins), .a_in(a32), .b_in(b32),
        .mem_addr(mem_addr32), .mem_req(mem_req32), .mem_ack(1'b0), .mem_rdata(32'd0),
        .out(out32), .busy(busy32), .done(done32), .err(err32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-18s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out", 64'(out), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_req", 64'(mem_req), 64'h0);
        chk("rst_addr", 64'(mem_addr), 64'h0);
        rst = 1'b0;

        // 1: A, immediate, lane 1
        @(negedge clk);
        a_in = 16'hABCD; ins = 16'h0512; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = 16'h0000;
        chk("t1_done", 64'(done), 64'h1);
        chk("t1_out", 64'(out), 64'h12CD);
        chk("t1_err", 64'(err), 64'h0);
        chk("t1_busy", 64'(busy), 64'h1);
        @(negedge clk);
        chk("t1_done_drop", 64'(done), 64'h0);
        chk("t1_idle", 64'(busy), 64'h0);

        // 2: B, immediate, lane 0; then illegal lane 2
        b_in = 16'h1234; ins = 16'h0C3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_out", 64'(out), 64'h123C);
        chk("t2_done", 64'(done), 64'h1);
        @(negedge clk);
        ins = 16'h0E00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_lane_err", 64'(err), 64'h1);
        chk("t2_lane_done", 64'(done), 64'h1);
        chk("t2_lane_held", 64'(out), 64'h123C);
        @(negedge clk);
        chk("t2_err_drop", 64'(err), 64'h0);

        // 3: indexed memory load, early ack ignored, ack on 4th req cycle
        a_in = 16'h00F0; ins = 16'h0240; start = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0; a_in = 16'hFFFF;
        chk("t3_addr", 64'(mem_addr), 64'h30);
        chk("t3_req", 64'(mem_req), 64'h1);
        chk("t3_done_early", 64'(done), 64'h0);
        repeat (2) @(negedge clk);
        chk("t3_req_c3", 64'(mem_req), 64'h1);
        chk("t3_addr_c3", 64'(mem_addr), 64'h30);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("t3_done", 64'(done), 64'h1);
        chk("t3_out", 64'(out), 64'hBEEF);
        chk("t3_err", 64'(err), 64'h0);
        chk("t3_req_drop", 64'(mem_req), 64'h0);
        @(negedge clk);

        // 4: timeout, ack never arrives
        ins = 16'h0011; start = 1'b1;
        req_cnt = 0; done_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_at = i;
                break;
            end
            if (mem_req) req_cnt++;
        end
        chk("t4_req_cycles", 64'(req_cnt), 64'd15);
        chk("t4_done_cycle", 64'(done_at), 64'd16);
        chk("t4_err", 64'(err), 64'h1);
        chk("t4_out_held", 64'(out), 64'hBEEF);
        chk("t4_req_low", 64'(mem_req), 64'h0);
        @(negedge clk);

        // 4b: ack on the 15th req cycle wins over the timeout
        ins = 16'h0022; start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 15) begin
                mem_ack = 1'b1; mem_rdata = 16'h5A5A;
            end
        end
        chk("t4b_req_c15", 64'(mem_req), 64'h1);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t4b_done", 64'(done), 64'h1);
        chk("t4b_err", 64'(err), 64'h0);
        chk("t4b_out", 64'(out), 64'h5A5A);
        @(negedge clk);

        // 5: start while busy ignored, reset during REQ
        ins = 16'h0040; start = 1'b1;
        @(negedge clk);
        ins = 16'h0511; a_in = 16'h7777;
        chk("t5_addr", 64'(mem_addr), 64'h40);
        @(negedge clk);
        start = 1'b0;
        chk("t5_busy_req", 64'(mem_req), 64'h1);
        chk("t5_addr_kept", 64'(mem_addr), 64'h40);
        chk("t5_no_done", 64'(done), 64'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_req", 64'(mem_req), 64'h0);
        chk("t5_rst_busy", 64'(busy), 64'h0);
        chk("t5_rst_out", 64'(out), 64'h0);
        chk("t5_rst_addr", 64'(mem_addr), 64'h0);
        ins = 16'h0055; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_fresh_addr", 64'(mem_addr), 64'h55);
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t5_fresh_done", 64'(done), 64'h1);
        chk("t5_fresh_out", 64'(out), 64'hCAFE);
        // start in the done cycle is dropped; held into the next cycle it is accepted
        a_in = 16'hABCD; ins = 16'h0512; start = 1'b1;
        @(negedge clk);
        chk("t5_dropped_busy", 64'(busy), 64'h0);
        chk("t5_dropped_out", 64'(out), 64'hCAFE);
        @(negedge clk);
        start = 1'b0;
        chk("t5_next_done", 64'(done), 64'h1);
        chk("t5_next_out", 64'(out), 64'h12CD);
        @(negedge clk);

        // 6: 32-bit datapath, lane 3
        a32 = 32'h11223344; ins = 16'h07AA; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        chk("t6_done", 64'(done32), 64'h1);
        chk("t6_out", 64'(out32), 64'hAA223344);
        chk("t6_err", 64'(err32), 64'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
